// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, segment codes and helpers for the 7-segment
//               display slice.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0     = 7'b1000000;
    localparam logic [6:0] c_seg_1     = 7'b1111001;
    localparam logic [6:0] c_seg_2     = 7'b0100100;
    localparam logic [6:0] c_seg_3     = 7'b0110000;
    localparam logic [6:0] c_seg_4     = 7'b0011001;
    localparam logic [6:0] c_seg_5     = 7'b0010010;
    localparam logic [6:0] c_seg_6     = 7'b0000010;
    localparam logic [6:0] c_seg_7     = 7'b1111000;
    localparam logic [6:0] c_seg_8     = 7'b0000000;
    localparam logic [6:0] c_seg_9     = 7'b0010000;
    localparam logic [6:0] c_seg_blank = 7'b1111111;

    // True when every DATA_WIDTH-bit value fits in num_digits decimal digits
    function automatic logic digits_fit(input int data_width, input int num_digits);
        longint max_bin;
        longint max_dec;
        max_bin = (longint'(1) << data_width) - 1;
        max_dec = 1;
        for (int i = 0; i < num_digits; i++) begin
            max_dec = max_dec * 10;
        end
        return (max_bin <= max_dec - 1);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return c_seg_0;
            4'd1:    return c_seg_1;
            4'd2:    return c_seg_2;
            4'd3:    return c_seg_3;
            4'd4:    return c_seg_4;
            4'd5:    return c_seg_5;
            4'd6:    return c_seg_6;
            4'd7:    return c_seg_7;
            4'd8:    return c_seg_8;
            4'd9:    return c_seg_9;
            default: return c_seg_blank;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd
// Description : Sequential shift-add-3 binary to BCD converter; restarts
//               whenever the input differs from the last converted value.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd
    import seg7_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [DATA_WIDTH-1:0]   bin_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    busy_o
);

    localparam int c_work_w = 4 * NUM_DIGITS;
    localparam int c_cnt_w  = $clog2(DATA_WIDTH + 1);

    conv_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_last;
    logic [DATA_WIDTH-1:0] r_bin;
    logic [c_work_w-1:0]   r_work;
    logic [c_work_w-1:0]   r_bcd;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_busy;
    logic [c_work_w-1:0]   w_adj;

    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
            r_last  <= '0;
            r_bin   <= '0;
            r_work  <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bin_i != r_last) begin
                        r_bin   <= bin_i;
                        r_last  <= bin_i;
                        r_work  <= '0;
                        r_cnt   <= c_cnt_w'(DATA_WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= {w_adj[c_work_w-2:0], r_bin[DATA_WIDTH-1]};
                    r_bin  <= r_bin << 1;
                    r_cnt  <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_work;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o  = r_bcd;
    assign busy_o = r_busy;

endmodule
`default_nettype wire

// File: rtl/seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display
// Description : Multiplexed decimal display: binary-to-BCD conversion,
//               digit scanning, leading-zero blanking and segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display
    import seg7_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [6:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic                  busy_o
);

    localparam int c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (!digits_fit(DATA_WIDTH, NUM_DIGITS)) begin : g_digit_check
        $error("seg7_display: NUM_DIGITS too small for DATA_WIDTH");
    end

    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_zero_above;
    logic [3:0]              w_nib;
    logic                    w_cur_blank;
    logic [c_ref_w-1:0]      r_refresh;
    logic [c_idx_w-1:0]      r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    bin2bcd #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bin_i  (data_i),
        .bcd_o  (w_bcd),
        .busy_o (busy_o)
    );

    // A digit is blank only when it and everything above it are zero
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (w_bcd[4*i +: 4] == 4'd0);
            w_blank[i]   = (BLANK_LZ != 0) && w_zero_above;
        end
    end

    always_comb begin
        w_nib       = 4'd0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib       = w_bcd[4*i +: 4];
                w_cur_blank = w_blank[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= '1;
            r_an      <= '1;
        end else begin
            if (r_refresh == c_ref_w'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                if (r_idx == c_idx_w'(NUM_DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end else begin
                r_refresh <= r_refresh + c_ref_w'(1);
            end
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_cur_blank ? c_seg_blank : seg_decode(w_nib);
        end
    end

    assign seg_o = r_seg;
    assign an_o  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display
// Description : Self-checking bench for seg7_display against a decimal
//               reference model of the scanned display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display;

    localparam int DATA_WIDTH  = 8;
    localparam int NUM_DIGITS  = 3;
    localparam int REFRESH_DIV = 4;

    logic                  clk;
    logic                  rstn;
    logic [DATA_WIDTH-1:0] data;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  busy;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt;
    int cur_val;

    seg7_display #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (1)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .data_i (data),
        .seg_o  (seg),
        .an_o   (an),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since the last reset release
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] model_seg(input int v, input int d);
        int p;
        int dig;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d > 0 && v < p) return 7'b1111111;
        dig = (v / p) % 10;
        case (dig)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic int model_idx(input int k);
        return ((k - 1) / REFRESH_DIV) % NUM_DIGITS;
    endfunction

    // Check one full scan of the display for a stable value
    task automatic scan_check(input int v, input string tag);
        int d;
        logic [NUM_DIGITS-1:0] exp_an;
        for (int c = 0; c < REFRESH_DIV * NUM_DIGITS; c++) begin
            @(negedge clk);
            d      = model_idx(edge_cnt);
            exp_an = ~(NUM_DIGITS'(1) << d);
            check($sformatf("%s an c%0d", tag, c), 32'(an), 32'(exp_an));
            check($sformatf("%s seg d%0d", tag, d), 32'(seg), 32'(model_seg(v, d)));
        end
    endtask

    // Apply a new value; optionally change it again a few cycles into the run
    task automatic convert(input int v, input bit chg, input int v2, input string tag);
        int guard;
        int cnt;
        @(posedge clk); #1;
        data = DATA_WIDTH'(v);
        guard = 0;
        while (!busy && guard < 5) begin @(negedge clk); guard++; end
        check({tag, " start"}, 32'(busy), 32'd1);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (chg && cnt == 3) data = DATA_WIDTH'(v2);
            @(negedge clk);
        end
        check({tag, " busy len"}, 32'(cnt), 32'd9);
        cur_val = v;
        if (chg) begin
            guard = 0;
            while (!busy && guard < 5) begin @(negedge clk); guard++; end
            check({tag, " restart"}, 32'(busy), 32'd1);
            cnt = 0;
            while (busy && cnt < 40) begin cnt++; @(negedge clk); end
            check({tag, " busy len2"}, 32'(cnt), 32'd9);
            cur_val = v2;
        end
        repeat (2) @(negedge clk);
        scan_check(cur_val, tag);
    endtask

    initial begin
        int v;
        rstn = 1'b0;
        data = '0;
        cur_val = 0;
        #12;
        check("rst seg", 32'(seg), 32'h7f);
        check("rst an", 32'(an), 32'h7);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("first an", 32'(an), 32'b110);
        check("first seg", 32'(seg), 32'b1000000);
        check("idle busy", 32'(busy), 32'd0);
        scan_check(0, "zero");

        convert(255, 1'b0, 0, "v255");
        convert(0, 1'b0, 0, "wrap0");
        convert(105, 1'b0, 0, "v105");
        convert(12, 1'b1, 13, "v12_13");

        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 255));
            if (v == cur_val) v = v ^ 1;
            convert(v, 1'b0, 0, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a conversion
        @(posedge clk); #1;
        data = 8'd200;
        repeat (4) @(negedge clk);
        check("pre-abort busy", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("abort seg", 32'(seg), 32'h7f);
        check("abort an", 32'(an), 32'h7);
        check("abort busy", 32'(busy), 32'd0);
        data = '0;
        @(negedge clk);
        rstn = 1'b1;
        scan_check(0, "post-abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
